// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: valid/ready data bus between the memory stage and memory.
// The stage is master; the memory/slave answers with ready and read data.
interface lsu_mem_stage_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_be,
    output bus_wdata,
    input  bus_ready,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_be,
    input  bus_wdata,
    output bus_ready,
    output bus_rdata
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store stage with byte lanes, store replication,
// load extension, and misaligned/illegal/timeout fault reporting.
module lsu_mem_stage #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [1:0]  fault_cause,
  lsu_mem_stage_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    FAULT
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [TO_W-1:0] cnt;
  logic [2:0]      f3_q;
  logic [1:0]      lane_q;
  logic            req;
  logic            illegal;
  logic            misal;
  logic [3:0]      be;
  logic [31:0]     wd;
  logic [7:0]      bt;
  logic [15:0]     hw;
  logic [31:0]     ext;

  assign req = mem_read | mem_write;

  // Reset forces stall low even with a request pending in IDLE.
  assign stall = rst & ((state == IDLE && req) || state == BUSY);

  always_comb begin
    illegal = 1'b0;
    misal   = 1'b0;
    be      = 4'b0000;
    wd      = wdata;
    if (mem_read && mem_write)
      illegal = 1'b1;
    else if (mem_write)
      illegal = funct3[2] | (funct3[1:0] == 2'b11);
    else
      illegal = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
    unique case (1'b1)
      (funct3[1:0] == 2'b00): begin
        be = 4'b0001 << addr[1:0];
        wd = {4{wdata[7:0]}};
      end
      (funct3[1:0] == 2'b01): begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wd    = {2{wdata[15:0]}};
        misal = addr[0];
      end
      (funct3[1:0] == 2'b10): begin
        be    = 4'b1111;
        misal = |addr[1:0];
      end
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    bt  = bus.bus_rdata[{lane_q, 3'b000} +: 8];
    hw  = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    ext = bus.bus_rdata;
    unique case (1'b1)
      (f3_q == 3'b000): ext = {{24{bt[7]}}, bt};
      (f3_q == 3'b001): ext = {{16{hw[15]}}, hw};
      (f3_q == 3'b100): ext = {24'd0, bt};
      (f3_q == 3'b101): ext = {16'd0, hw};
      default:          ext = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      f3_q          <= 3'b000;
      lane_q        <= 2'b00;
      rdata         <= 32'd0;
      fault         <= 1'b0;
      fault_cause   <= 2'b00;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'd0;
      bus.bus_be    <= 4'b0000;
      bus.bus_wdata <= 32'd0;
    end else begin
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            bus.bus_addr  <= {addr[31:2], 2'b00};
            bus.bus_be    <= be;
            bus.bus_wdata <= wd;
            bus.bus_we    <= mem_write;
            f3_q          <= funct3;
            lane_q        <= addr[1:0];
            cnt           <= '0;
            if (illegal) begin
              state       <= FAULT;
              fault       <= 1'b1;
              fault_cause <= 2'b11;
            end else if (misal) begin
              state       <= FAULT;
              fault       <= 1'b1;
              fault_cause <= 2'b01;
            end else begin
              state       <= BUSY;
              bus.bus_req <= 1'b1;
            end
          end
        end
        BUSY: begin
          // Ready in the final allowed cycle still completes the access.
          if (bus.bus_ready) begin
            state       <= DONE;
            bus.bus_req <= 1'b0;
            if (!bus.bus_we) rdata <= ext;
          end else if (TIMEOUT_CYCLES != 0 && cnt == TO_LAST) begin
            state       <= FAULT;
            fault       <= 1'b1;
            fault_cause <= 2'b10;
            bus.bus_req <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
